// File: rtl/sirv_pwm8_tlarb_if.sv
// TileLink-UL style A/D channel bundle used for both the requester ports and the
// downstream PWM8 register port of the arbiter.
interface sirv_pwm8_tlarb_if #(
  parameter int AW   = 29,
  parameter int SRCW = 5
) ();
  logic            a_valid;
  logic            a_ready;
  logic [2:0]      a_opcode;
  logic [2:0]      a_size;
  logic [SRCW-1:0] a_source;
  logic [AW-1:0]   a_address;
  logic [3:0]      a_mask;
  logic [31:0]     a_data;
  logic            d_valid;
  logic            d_ready;
  logic [2:0]      d_opcode;
  logic [SRCW-1:0] d_source;
  logic [31:0]     d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_source, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_source, d_data
  );
endinterface

// File: rtl/sirv_pwm8_tlarb.sv
// Two-requester arbiter sharing one PWM8 register port: one transaction in flight,
// round-robin between simultaneous requesters, request fields held until completion.
module sirv_pwm8_tlarb #(
  parameter int AW   = 29,
  parameter int SRCW = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  sirv_pwm8_tlarb_if.slave  m0,
  sirv_pwm8_tlarb_if.slave  m1,
  sirv_pwm8_tlarb_if.master s,
  output logic              grant_id,
  output logic              busy
);
  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic [2:0]      opcode;
    logic [2:0]      size;
    logic [SRCW-1:0] source;
    logic [AW-1:0]   address;
    logic [3:0]      mask;
    logic [31:0]     data;
  } a_req_t;

  state_t state_r;
  state_t state_nxt_s;
  a_req_t hold_r;
  a_req_t win_req_s;
  logic   last_grant_r;
  logic   grant_r;
  logic   win_s;
  logic   accept_s;
  logic   busy_s;
  logic   d_ready_s;
  logic   done_s;

  // Arbitration: on a tie the requester not granted last wins; reset gates acceptance
  always_comb begin
    if (m0.a_valid && m1.a_valid) begin
      win_s = ~last_grant_r;
    end else if (m1.a_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      win_req_s = {m1.a_opcode, m1.a_size, m1.a_source, m1.a_address, m1.a_mask, m1.a_data};
    end else begin
      win_req_s = {m0.a_opcode, m0.a_size, m0.a_source, m0.a_address, m0.a_mask, m0.a_data};
    end
    busy_s    = (state_r == BUSY);
    accept_s  = reset_n && !busy_s && (m0.a_valid || m1.a_valid);
    d_ready_s = grant_r ? m1.d_ready : m0.d_ready;
    done_s    = busy_s && s.a_ready && s.d_valid && d_ready_s;
  end

  // Next-state logic for the IDLE/BUSY controller
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Port steering: downstream driven from the holding register, D routed to the owner
  always_comb begin
    m0.a_ready = accept_s && !win_s;
    m1.a_ready = accept_s && win_s;

    s.a_valid   = busy_s;
    s.a_opcode  = hold_r.opcode;
    s.a_size    = hold_r.size;
    s.a_source  = hold_r.source;
    s.a_address = hold_r.address;
    s.a_mask    = hold_r.mask;
    s.a_data    = hold_r.data;
    s.d_ready   = busy_s && d_ready_s;

    m0.d_valid  = busy_s && !grant_r && s.d_valid;
    m0.d_opcode = s.d_opcode;
    m0.d_source = s.d_source;
    m0.d_data   = s.d_data;
    m1.d_valid  = busy_s && grant_r && s.d_valid;
    m1.d_opcode = s.d_opcode;
    m1.d_source = s.d_source;
    m1.d_data   = s.d_data;
  end

  // State, round-robin history, owner index and request capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      hold_r       <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        last_grant_r <= win_s;
        grant_r      <= win_s;
        hold_r       <= win_req_s;
      end
    end
  end

  assign grant_id = grant_r;
  assign busy     = busy_s;
endmodule

// File: tb/tb_sirv_pwm8_tlarb.sv
// Self-checking bench for sirv_pwm8_tlarb: reset checks, a cycle table for
// round-robin alternation, directed corner sequences and a randomized run.
module tb_sirv_pwm8_tlarb;
  localparam int AW   = 29;
  localparam int SRCW = 5;

  typedef struct packed {
    logic [2:0]      op;
    logic [2:0]      size;
    logic [SRCW-1:0] src;
    logic [AW-1:0]   adr;
    logic [3:0]      msk;
    logic [31:0]     dat;
  } req_t;

  typedef struct {
    logic        v0, v1;
    req_t        r0, r1;
    logic        sar, sdv, dr0, dr1;
    logic [31:0] sddat;
  } stim_t;

  // inputs {v0 v1 sdv dr1}, expected {ar0 ar1 s_a_valid busy d0 d1 grant_id}
  typedef struct packed {
    logic v0, v1, sdv, dr1;
    logic ar0, ar1, sav, bsy, d0, d1, gid;
  } vec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic grant_id;
  logic busy;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  bit   inflight = 1'b0;
  int   owner    = 0;
  int   last_w   = 1;
  int   gid      = 0;
  req_t held     = '0;

  sirv_pwm8_tlarb_if #(.AW(AW), .SRCW(SRCW)) m0_if ();
  sirv_pwm8_tlarb_if #(.AW(AW), .SRCW(SRCW)) m1_if ();
  sirv_pwm8_tlarb_if #(.AW(AW), .SRCW(SRCW)) s_if ();

  sirv_pwm8_tlarb #(.AW(AW), .SRCW(SRCW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .m0       (m0_if),
    .m1       (m1_if),
    .s        (s_if),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.op   = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
    r.size = 3'($urandom_range(0, 2));
    r.src  = SRCW'($urandom());
    r.adr  = AW'($urandom());
    r.msk  = 4'($urandom());
    r.dat  = $urandom();
    return r;
  endfunction

  function automatic stim_t base_stim();
    stim_t st;
    st.v0 = 1'b0;  st.v1 = 1'b0;
    st.r0 = rnd_req(); st.r1 = rnd_req();
    st.sar = 1'b1; st.sdv = 1'b1; st.dr0 = 1'b1; st.dr1 = 1'b1;
    st.sddat = $urandom();
    return st;
  endfunction

  // The downstream responder echoes the source and answers Get with AccessAckData (1)
  task automatic drive(input stim_t st);
    m0_if.a_valid = st.v0;       m1_if.a_valid = st.v1;
    m0_if.a_opcode = st.r0.op;   m1_if.a_opcode = st.r1.op;
    m0_if.a_size = st.r0.size;   m1_if.a_size = st.r1.size;
    m0_if.a_source = st.r0.src;  m1_if.a_source = st.r1.src;
    m0_if.a_address = st.r0.adr; m1_if.a_address = st.r1.adr;
    m0_if.a_mask = st.r0.msk;    m1_if.a_mask = st.r1.msk;
    m0_if.a_data = st.r0.dat;    m1_if.a_data = st.r1.dat;
    m0_if.d_ready = st.dr0;      m1_if.d_ready = st.dr1;
    s_if.a_ready  = st.sar;
    s_if.d_valid  = st.sdv;
    s_if.d_data   = st.sddat;
    s_if.d_source = s_if.a_source;
    s_if.d_opcode = (s_if.a_opcode == 3'd4) ? 3'd1 : 3'd0;
  endtask

  task automatic model_check(input stim_t st, input int win);
    logic own_dv;
    logic oth_dv;
    chk("busy", busy, inflight);
    chk("grant_id", grant_id, gid[0]);
    chk("s_a_valid", s_if.a_valid, inflight);
    if (!inflight) begin
      chk("m0_a_ready", m0_if.a_ready, (st.v0 || st.v1) && win == 0);
      chk("m1_a_ready", m1_if.a_ready, (st.v0 || st.v1) && win == 1);
      chk("s_d_ready_idle", s_if.d_ready, 1'b0);
      chk("m0_d_valid_idle", m0_if.d_valid, 1'b0);
      chk("m1_d_valid_idle", m1_if.d_valid, 1'b0);
    end else begin
      chk("a_ready_busy", {m0_if.a_ready, m1_if.a_ready}, 2'b00);
      chk("s_a_fields", {s_if.a_opcode, s_if.a_size, s_if.a_source, s_if.a_address,
                         s_if.a_mask, s_if.a_data}, held);
      chk("s_d_ready", s_if.d_ready, (owner == 1) ? st.dr1 : st.dr0);
      own_dv = (owner == 1) ? m1_if.d_valid : m0_if.d_valid;
      oth_dv = (owner == 1) ? m0_if.d_valid : m1_if.d_valid;
      chk("owner_d_valid", own_dv, st.sdv);
      chk("other_d_valid", oth_dv, 1'b0);
      if (st.sdv) begin
        if (owner == 1) begin
          chk("m1_d_resp", {m1_if.d_opcode, m1_if.d_source, m1_if.d_data},
              {((held.op == 3'd4) ? 3'd1 : 3'd0), held.src, st.sddat});
        end else begin
          chk("m0_d_resp", {m0_if.d_opcode, m0_if.d_source, m0_if.d_data},
              {((held.op == 3'd4) ? 3'd1 : 3'd0), held.src, st.sddat});
        end
      end
    end
  endtask

  task automatic model_update(input stim_t st, input int win);
    if (!inflight) begin
      if (st.v0 || st.v1) begin
        inflight = 1'b1;
        owner    = win;
        held     = (win == 1) ? st.r1 : st.r0;
        last_w   = win;
        gid      = win;
      end
    end else if (st.sar && st.sdv && ((owner == 1) ? st.dr1 : st.dr0)) begin
      inflight = 1'b0;
    end
  endtask

  task automatic model_reset();
    inflight = 1'b0; owner = 0; last_w = 1; gid = 0; held = '0;
  endtask

  // One clock cycle: drive after the edge, check mid-cycle, advance the model
  task automatic step(input stim_t st);
    int win;
    @(posedge clock);
    cyc++;
    #1;
    drive(st);
    #3;
    if (st.v0 && st.v1) win = (last_w == 0) ? 1 : 0;
    else win = st.v1 ? 1 : 0;
    model_check(st, win);
    model_update(st, win);
  endtask

  initial begin
    vec_t  tbl[11];
    stim_t st;
    int    prev_acc;
    logic [SRCW-1:0] srcq[$];

    tbl[0]  = {4'b1111, 7'b1000000};
    tbl[1]  = {4'b1111, 7'b0011100};
    tbl[2]  = {4'b1111, 7'b0100000};
    tbl[3]  = {4'b1111, 7'b0011011};
    tbl[4]  = {4'b1111, 7'b1000001};
    tbl[5]  = {4'b1111, 7'b0011100};
    tbl[6]  = {4'b0111, 7'b0100000};
    tbl[7]  = {4'b0001, 7'b0011001};
    tbl[8]  = {4'b0010, 7'b0011011};
    tbl[9]  = {4'b0011, 7'b0011011};
    tbl[10] = {4'b0011, 7'b0000001};

    // Reset state, with requests present so that a_ready gating is visible
    st = base_stim(); st.v0 = 1'b1; st.v1 = 1'b1;
    drive(st);
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_s_a_valid", s_if.a_valid, 1'b0);
    chk("rst_a_ready", {m0_if.a_ready, m1_if.a_ready}, 2'b00);
    chk("rst_d_valid", {m0_if.d_valid, m1_if.d_valid, s_if.d_ready}, 3'b000);
    chk("rst_hold", {s_if.a_opcode, s_if.a_address, s_if.a_data}, '0);
    st.v0 = 1'b0; st.v1 = 1'b0;
    drive(st);
    reset_n = 1'b1;

    // Cycle table: tie from reset goes to m0, then strict alternation
    for (int i = 0; i < 11; i++) begin
      st = base_stim();
      st.v0 = tbl[i].v0; st.v1 = tbl[i].v1; st.sdv = tbl[i].sdv; st.dr1 = tbl[i].dr1;
      step(st);
      chk($sformatf("tbl%0d", i),
          {m0_if.a_ready, m1_if.a_ready, s_if.a_valid, busy, m0_if.d_valid, m1_if.d_valid, grant_id},
          {tbl[i].ar0, tbl[i].ar1, tbl[i].sav, tbl[i].bsy, tbl[i].d0, tbl[i].d1, tbl[i].gid});
    end

    // m0 Get to 0x08, response 0x5A one cycle after accept
    st = base_stim(); st.v0 = 1'b1; st.r0.op = 3'd4; st.r0.adr = AW'(8);
    step(st);
    chk("get_accept", m0_if.a_ready, 1'b1);
    st = base_stim(); st.sddat = 32'h0000_005A;
    step(st);
    chk("get_resp", {m0_if.d_valid, m1_if.d_valid, m0_if.d_data}, {1'b1, 1'b0, 32'h0000_005A});
    chk("get_addr", s_if.a_address, AW'(8));

    // m1 write stalled by d_ready for 5 cycles while m0 waits
    st = base_stim(); st.v1 = 1'b1; st.r1.op = 3'd0; st.r1.msk = 4'hF;
    st.r1.dat = 32'h0000_0003; st.r1.adr = '0;
    step(st);
    for (int i = 0; i < 5; i++) begin
      st = base_stim(); st.v0 = 1'b1; st.dr1 = 1'b0;
      step(st);
      chk($sformatf("stall%0d", i),
          {s_if.a_valid, busy, m0_if.a_ready, s_if.a_mask, s_if.a_data, s_if.a_address},
          {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0003, AW'(0)});
    end
    st = base_stim(); st.v0 = 1'b1;
    step(st);
    chk("stall_complete", {m1_if.d_valid, s_if.d_ready}, 2'b11);
    st = base_stim(); st.v0 = 1'b1;
    step(st);
    chk("m0_after_m1", {busy, m0_if.a_ready}, 2'b01);
    st = base_stim();
    step(st);

    // Back-to-back m0 requests: accepts every 2 cycles, source echoed
    prev_acc = -1;
    for (int i = 0; i < 8; i++) begin
      st = base_stim(); st.v0 = 1'b1; st.r0.src = SRCW'(i + 7);
      step(st);
      if (m0_if.a_ready) begin
        if (prev_acc >= 0) chk("accept_gap", 32'(cyc - prev_acc), 32'd2);
        prev_acc = cyc;
        srcq.push_back(st.r0.src);
      end
      if (m0_if.d_valid && srcq.size() > 0) chk("src_echo", m0_if.d_source, srcq.pop_front());
    end
    st = base_stim();
    step(st);

    // Reset pulsed mid-BUSY aborts the transaction
    st = base_stim(); st.v0 = 1'b1;
    step(st);
    st.sdv = 1'b0;
    step(st);
    reset_n = 1'b0;
    #1;
    chk("abort", {busy, s_if.a_valid, m0_if.d_valid, m1_if.d_valid, m0_if.a_ready}, 5'b00000);
    model_reset();
    st = base_stim();
    drive(st);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st = base_stim();
      step(st);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      st = base_stim();
      st.v0  = ($urandom_range(0, 2) != 0);
      st.v1  = ($urandom_range(0, 2) != 0);
      st.sar = ($urandom_range(0, 3) != 0);
      st.sdv = ($urandom_range(0, 3) != 0);
      st.dr0 = ($urandom_range(0, 3) != 0);
      st.dr1 = ($urandom_range(0, 3) != 0);
      step(st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sirv_pwm8_tlarb.md
SIRV_PWM8_TLARB -- requirements
Module: sirv_pwm8_tlarb

Interface
REQ-001 Parameter AW, default 29: width of the a_address fields.
REQ-002 Parameter SRCW, default 5: width of the a_source and d_source fields.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 mN_a_valid/mN_a_ready (N=0,1)  in/out  1  A-channel handshake, requester N.
REQ-006 mN_a_opcode/size  input  3 each  requester N opcode and size; opcode 4 = Get, any other value = write.
REQ-007 mN_a_source  input  SRCW  requester N source ID.
REQ-008 mN_a_address  input  AW  requester N address.
REQ-009 mN_a_mask  input  4  requester N byte mask.
REQ-010 mN_a_data  input  32  requester N write data.
REQ-011 mN_d_valid/mN_d_ready  out/in  1  D-channel handshake, requester N.
REQ-012 mN_d_opcode  output  3  response opcode to requester N.
REQ-013 mN_d_source  output  SRCW  response source ID to requester N.
REQ-014 mN_d_data  output  32  response data to requester N.
REQ-015 s_a_*  output  same widths as mN_a_*  single downstream A channel to the PWM8 register port: valid, opcode, size, source, address, mask, data.
REQ-016 s_a_ready  input  1  downstream A ready.
REQ-017 s_d_valid, s_d_opcode[3], s_d_source[SRCW], s_d_data[32]  input  downstream D channel.
REQ-018 s_d_ready  output  1  downstream D ready.
REQ-019 grant_id  output  1  index of the requester currently owning the downstream port.
REQ-020 busy  output  1  high while a transaction is in flight.

Function
REQ-021 The block shall shares one downstream register port between two requesters using a two-state FSM, IDLE and BUSY; the downstream port may be combinational (a_ready tied to d_ready, d_valid to a_valid).
REQ-022 In IDLE, s_a_valid, s_d_ready, m0_d_valid and m1_d_valid shall be 0, and busy shall be 0.
REQ-023 In IDLE, if exactly one mN_a_valid is high, that requester shall win; its mN_a_ready shall be 1 in the same cycle (the loser's a_ready is 0), and the FSM shall enter BUSY on the next edge.
REQ-024 If both requesters are valid in IDLE, the one not granted last (round-robin via a last_grant register) shall win; last_grant shall update to the winner on acceptance.
REQ-025 On acceptance, all of the winner's A fields shall be captured into a holding register, and grant_id shall take the winner's index.
REQ-026 In BUSY, s_a_valid shall be 1, s_a_* shall be driven from the holding register, and the mN_a_ready of both requesters shall be 0.
REQ-027 In BUSY, m[grant]_d_valid/opcode/source/data shall equal the s_d_* inputs, s_d_ready shall equal m[grant]_d_ready, and the other requester's d_valid shall be 0.
REQ-028 The transaction shall complete when s_a_valid & s_a_ready & s_d_valid & s_d_ready are all true in BUSY; the FSM shall return to IDLE on that edge.
REQ-029 If s_a_ready is high without s_d_valid, or the reverse, the block shall stay in BUSY with the request held.
REQ-030 Minimum latency: accept at cycle N, response at cycle N+1 with zero downstream wait; peak throughput is one transaction per 2 cycles.
REQ-031 A requester stalling d_ready shall hold the FSM in BUSY indefinitely, with no timeout; the other requester shall wait.
REQ-032 Holding-register contents shall change only on acceptance.

Reset
REQ-033 Assertion of reset_n=0 shall, asynchronously, force the FSM to IDLE, last_grant=1 (so m0 wins the first tie), grant_id=0, busy=0, the holding register to 0, and all valid/ready outputs to 0.
REQ-034 Reset asserted while in BUSY shall abort the in-flight transaction, with no response delivered after release.
REQ-035 After reset_n deasserts, arbitration shall start on the first rising edge.

Verification
REQ-036 Scenario: m0 issues Get to addr 0x08, downstream returns data 0x5A -> m0_d_valid=1 one cycle after accept with data 0x5A; m1_d_valid=0 throughout.
REQ-037 Scenario: m0 and m1 request simultaneously from reset -> m0 is served first, m1 second; with both still requesting, the next grant goes to m0 (strict alternation).
REQ-038 Scenario: m1 write with mask 0xF and data 0x00000003 to addr 0x00, m1_d_ready held low for 5 cycles -> s_a_valid stays 1 with stable fields, busy=1, m0 a_ready=0 for those 5 cycles; completion occurs on the cycle d_ready rises.
REQ-039 Scenario: m0 requests while m1 is BUSY -> m0_a_ready stays 0 until m1 completes; m0 is accepted in the first IDLE cycle.
REQ-040 Scenario: reset_n pulsed low mid-BUSY -> busy=0 and s_a_valid=0 immediately, with no stray d_valid on either requester after release.
REQ-041 Scenario: back-to-back m0 requests -> accepts spaced exactly 2 cycles apart, and source IDs are echoed unchanged on m0_d_source.
